clarvi_load_align: RTL
======================

// Module: clarvi_load_align
// PURPOSE
//  Downstream of the memory-access stage. Collects the two 32-bit read responses of a split load
//  (access part 0 = low word, part 1 = high word) and merges them into 64 bits. Shifts by the byte
//  offset and sign/zero-extends by width, then hands a 64-bit writeback value plus rd to the regfile.
// PARAMETERS
//  XLEN          64  width of the writeback value
//  DROP_CNT_W     2  width of the counter of responses to discard after a flush
// PORTS
//  clock          in   1     system clock
//  reset          in   1     synchronous, active-high
//  stall          in   1     writeback stage stalled; hold the presented result
//  flush          in   1     squash the in-flight load (trap/interrupt)
//  req_valid      in   1     part-0 read issued this cycle (read_enable && access_part==0)
//  req_width      in   2     mem_width_t: B/H/W/D
//  req_unsigned   in   1     LBU/LHU/LWU: zero-extend
//  req_offset     in   2     byte offset within the word (word_offset)
//  req_rd         in   5     destination register
//  resp_valid     in   1     read_data valid; arrives 1 cycle after each read_enable
//  read_data      in   32    memory read word
//  result_valid   out  1     writeback value valid
//  result_data    out  XLEN  aligned, extended load value
//  result_rd      out  5     destination register of result_data
//  busy           out  1     load in flight (state != IDLE)
//  protocol_err   out  1     1-cycle pulse on a spurious response or a req while busy
// BEHAVIOUR
//  Reset: state=IDLE, result_valid=0, result_data=0, result_rd=0, busy=0, protocol_err=0, drop_cnt=0.
//  FSM (load_state_t): IDLE -> WAIT_LO -> WAIT_HI -> DONE -> IDLE.
//   IDLE:    on req_valid, latch width/unsigned/offset/rd and go to WAIT_LO.
//   WAIT_LO: on resp_valid, lo_q<=read_data and go to WAIT_HI.
//   WAIT_HI: on resp_valid, compute the result and go to DONE.
//   DONE:    result_valid=1; if !stall go to IDLE; if stall hold every output unchanged.
//  Arithmetic: raw = {hi,lo} >> (offset*8).
//   B: sign bit raw[7]; H: raw[15]; W: raw[31], then extend to XLEN.
//   D: no extension. D ignores req_unsigned; otherwise req_unsigned forces zero-extension.
//   A shift reaching past bit 63 fills the top with zeros before extension.
//  Latency: result_valid asserts the cycle after the hi response (req at T, lo T+1, hi T+2, valid T+3).
//  DONE+!stall+req_valid in the same cycle: accept the new req and go to WAIT_LO (back-to-back loads).
//  req_valid in WAIT_LO/WAIT_HI: ignore the req and pulse protocol_err.
//  resp_valid in IDLE/DONE with drop_cnt==0: ignore the response and pulse protocol_err.
//  flush: has priority over everything else.
//   Go to IDLE and clear result_valid.
//   drop_cnt += responses still owed (WAIT_LO: 2, WAIT_HI: 1), minus 1 if resp_valid is high that cycle.
//   While drop_cnt>0, each resp_valid decrements drop_cnt and is discarded without an error.
//   A req_valid while drop_cnt>0 is accepted; its responses are counted only after drop_cnt reaches 0.
//  reset mid-operation: immediate return to the reset state; drop_cnt cleared.
// CONFIGURATION
//  LOAD_RESULT_REG_EN defined: result_data/result_rd come from registers; timing as above.
//  Not defined: result is combinational from read_data in the WAIT_HI response cycle.
//   result_valid = resp_valid && state==WAIT_HI (latency T+2); DONE is used only while stall holds.
// STRUCTURE
//  riscv.svh / shared package: mem_width_t (existing), load_state_t enum, width constants.
//  Sub-module clarvi_load_extend (combinational): {hi,lo}, offset, width, unsigned -> XLEN value.
//  Shared with the store-side shifter tests.
// TESTING
//  LW offset 0, lo=32'h8000_0000, hi=x -> result 64'hFFFF_FFFF_8000_0000 at T+3, rd echoed.
//  LBU offset 3, lo=32'hAB00_0000 -> 64'h0000_0000_0000_00AB; LB same -> 64'hFFFF_FFFF_FFFF_FFAB.
//  LD offset 2, lo=32'h4433_2211, hi=32'h8877_6655 -> 64'h0000_8877_6655_4433.
//  stall held 3 cycles in DONE -> result_valid/data stable; back-to-back req on release accepted.
//  flush in WAIT_LO, then 2 resp, then new LH -> no protocol_err, new LH result correct.
//  resp_valid in IDLE -> protocol_err 1-cycle pulse, state stays IDLE.

Source files
------------

// File: rtl/clarvi_load_align_pkg.sv
// Shared load-path types: memory access width, load alignment FSM states and width constants.
package clarvi_load_align_pkg;

    localparam int XLEN_DEFAULT       = 64;
    localparam int DROP_CNT_W_DEFAULT = 2;
    localparam int WORD_W             = 32;
    localparam int RD_W               = 5;

    typedef enum logic [1:0] {
        MEM_WIDTH_B = 2'd0,
        MEM_WIDTH_H = 2'd1,
        MEM_WIDTH_W = 2'd2,
        MEM_WIDTH_D = 2'd3
    } mem_width_t;

    typedef enum logic [1:0] {
        LOAD_IDLE    = 2'd0,
        LOAD_WAIT_LO = 2'd1,
        LOAD_WAIT_HI = 2'd2,
        LOAD_DONE    = 2'd3
    } load_state_t;

    // Read responses still expected from memory for a load sitting in state s.
    function automatic logic [1:0] owed_responses(input load_state_t s);
        case (s)
            LOAD_WAIT_LO: return 2'd2;
            LOAD_WAIT_HI: return 2'd1;
            default:      return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/clarvi_load_extend.sv
// Combinational load shifter: aligns {hi,lo} by the byte offset and sign/zero-extends by width.
module clarvi_load_extend
    import clarvi_load_align_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [WORD_W-1:0] hi,
    input  logic [WORD_W-1:0] lo,
    input  logic [1:0]        offset,
    input  mem_width_t        width,
    input  logic              is_unsigned,
    output logic [XLEN-1:0]   value
);

    logic [2*WORD_W-1:0] raw;
    logic                sign_b;
    logic                sign_h;
    logic                sign_w;

    always_comb begin
        // Logical shift: bytes shifted in from beyond bit 63 are zero.
        raw    = {hi, lo} >> {offset, 3'b000};
        sign_b = !is_unsigned && raw[7];
        sign_h = !is_unsigned && raw[15];
        sign_w = !is_unsigned && raw[31];
        value  = XLEN'(raw);
        case (width)
            MEM_WIDTH_B: value = {{(XLEN-8){sign_b}}, raw[7:0]};
            MEM_WIDTH_H: value = {{(XLEN-16){sign_h}}, raw[15:0]};
            MEM_WIDTH_W: value = {{(XLEN-32){sign_w}}, raw[31:0]};
            MEM_WIDTH_D: value = XLEN'(raw);
            default:     value = XLEN'(raw);
        endcase
    end

endmodule

// File: rtl/clarvi_load_align.sv
// Split-load collector: merges the lo/hi read responses, aligns/extends them and presents rd + value.
// Build option LOAD_RESULT_REG_EN: registered result (valid 3 cycles after req) instead of combinational.
module clarvi_load_align
    import clarvi_load_align_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int DROP_CNT_W = DROP_CNT_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [1:0]        req_width,
    input  logic              req_unsigned,
    input  logic [1:0]        req_offset,
    input  logic [RD_W-1:0]   req_rd,
    input  logic              resp_valid,
    input  logic [WORD_W-1:0] read_data,
    output logic              result_valid,
    output logic [XLEN-1:0]   result_data,
    output logic [RD_W-1:0]   result_rd,
    output logic              busy,
    output logic              protocol_err
);

    localparam int SUM_W = DROP_CNT_W + 2;
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    load_state_t           state_q, state_d;
    mem_width_t            width_q, width_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic [RD_W-1:0]       rd_q, rd_d;
    logic [WORD_W-1:0]     lo_q, lo_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [RD_W-1:0]       result_rd_q, result_rd_d;
    logic                  perr_q, perr_d;

    logic [XLEN-1:0]       ext_value;
    logic                  drop_idle;
    logic                  resp_live;
    logic                  hi_fire;
    logic                  accept;
    logic [SUM_W-1:0]      drop_sum;

    // While responses of a squashed load are still owed, incoming responses belong to it.
    assign drop_idle = (drop_cnt_q == '0);
    assign resp_live = resp_valid && drop_idle;
    assign hi_fire   = !flush && resp_live && (state_q == LOAD_WAIT_HI);

    clarvi_load_extend #(
        .XLEN(XLEN)
    ) u_extend (
        .hi          (read_data),
        .lo          (lo_q),
        .offset      (off_q),
        .width       (width_q),
        .is_unsigned (uns_q),
        .value       (ext_value)
    );

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        uns_d       = uns_q;
        off_d       = off_q;
        rd_d        = rd_q;
        lo_d        = lo_q;
        drop_cnt_d  = drop_cnt_q;
        result_d    = result_q;
        result_rd_d = result_rd_q;
        perr_d      = 1'b0;
        accept      = 1'b0;

        // A response arriving in the flush cycle already pays off one owed response.
        drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(owed_responses(state_q));
        if (resp_valid && (drop_sum != '0)) begin
            drop_sum = drop_sum - SUM_W'(1);
        end

        if (flush) begin
            state_d    = LOAD_IDLE;
            drop_cnt_d = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_CNT_W-1:0];
        end else begin
            if (resp_valid && !drop_idle) begin
                drop_cnt_d = drop_cnt_q - DROP_CNT_W'(1);
            end
            case (state_q)
                LOAD_IDLE: begin
                    if (resp_live) perr_d = 1'b1;
                    if (req_valid) accept = 1'b1;
                end
                LOAD_WAIT_LO: begin
                    if (req_valid) perr_d = 1'b1;
                    if (resp_live) begin
                        lo_d    = read_data;
                        state_d = LOAD_WAIT_HI;
                    end
                end
                LOAD_WAIT_HI: begin
                    if (req_valid) perr_d = 1'b1;
                    if (resp_live) begin
                        result_d    = ext_value;
                        result_rd_d = rd_q;
`ifdef LOAD_RESULT_REG_EN
                        state_d     = LOAD_DONE;
`else
                        state_d     = stall ? LOAD_DONE : LOAD_IDLE;
`endif
                    end
                end
                LOAD_DONE: begin
                    if (resp_live) perr_d = 1'b1;
                    if (!stall) begin
                        if (req_valid) accept = 1'b1;
                        else           state_d = LOAD_IDLE;
                    end else if (req_valid) begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = LOAD_IDLE;
            endcase
            if (accept) begin
                width_d = mem_width_t'(req_width);
                uns_d   = req_unsigned;
                off_d   = req_offset;
                rd_d    = req_rd;
                state_d = LOAD_WAIT_LO;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= LOAD_IDLE;
            width_q     <= MEM_WIDTH_B;
            uns_q       <= 1'b0;
            off_q       <= 2'd0;
            rd_q        <= '0;
            lo_q        <= '0;
            drop_cnt_q  <= '0;
            result_q    <= '0;
            result_rd_q <= '0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            lo_q        <= lo_d;
            drop_cnt_q  <= drop_cnt_d;
            result_q    <= result_d;
            result_rd_q <= result_rd_d;
            perr_q      <= perr_d;
        end
    end

`ifdef LOAD_RESULT_REG_EN
    assign result_valid = (state_q == LOAD_DONE);
    assign result_data  = result_q;
    assign result_rd    = result_rd_q;
`else
    // DONE is only entered when the writeback stage stalls on a combinational result.
    assign result_valid = hi_fire || (state_q == LOAD_DONE);
    assign result_data  = hi_fire ? ext_value : result_q;
    assign result_rd    = hi_fire ? rd_q : result_rd_q;
`endif

    assign busy         = (state_q != LOAD_IDLE);
    assign protocol_err = perr_q;

endmodule
